// File: rtl/axi_line_write_master.sv
// Issues one 4-beat AXI INCR write burst per 128-bit line request and pulses done_o when the B response is accepted.
// Optional UNCACHE_WR_EN adds a single-beat uncached write path that has priority over line writes.
module axi_line_write_master #(
  parameter logic [3:0] AXI_ID = 4'b0001,
  parameter int         BEATS  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wen_i,
  input  logic [31:0]  waddr_i,
  input  logic [127:0] wdata_i,
  output logic         done_o,
  output logic         resp_err_o,
  output logic         busy_o,
`ifdef UNCACHE_WR_EN
  input  logic         unc_req_i,
  input  logic [31:0]  unc_addr_i,
  input  logic [31:0]  unc_data_i,
  input  logic [3:0]   unc_strb_i,
  output logic         unc_done_o,
`endif
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic [3:0]   awcache,
  output logic [2:0]   awprot,
  output logic [1:0]   awlock,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t       state, state_nxt;
  logic [31:0]  addr_q;
  logic [127:0] line_q;
  logic [1:0]   cnt;
  logic         is_last;
  logic         b_hs;
  logic         unc_sel;
  logic [3:0]   strb_sel;
  logic         start_req;
  logic         bid_unused;

  // Any bid is accepted since only one transaction is ever outstanding.
  assign bid_unused = ^bid;

`ifdef UNCACHE_WR_EN
  logic       unc_q;
  logic [3:0] strb_q;
  assign unc_sel   = unc_q;
  assign strb_sel  = strb_q;
  assign start_req = wen_i | unc_req_i;
`else
  assign unc_sel   = 1'b0;
  assign strb_sel  = 4'b1111;
  assign start_req = wen_i;
`endif

  // NOTE: every register here is updated with <= so all state advances from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 2'd0;
      addr_q <= 32'd0;
      line_q <= 128'd0;
`ifdef UNCACHE_WR_EN
      unc_q  <= 1'b0;
      strb_q <= 4'b1111;
`endif
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) begin
`ifdef UNCACHE_WR_EN
        if (unc_req_i) begin
          addr_q <= unc_addr_i;
          line_q <= {96'd0, unc_data_i};
          strb_q <= unc_strb_i;
          unc_q  <= 1'b1;
        end else if (wen_i) begin
          addr_q <= {waddr_i[31:4], 4'b0000};
          line_q <= wdata_i;
          strb_q <= 4'b1111;
          unc_q  <= 1'b0;
        end
`else
        if (wen_i) begin
          addr_q <= {waddr_i[31:4], 4'b0000};
          line_q <= wdata_i;
        end
`endif
      end
      if (state == S_AW) begin
        cnt <= 2'd0;
      end else if (state == S_W && wready) begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  assign is_last = unc_sel || (cnt == 2'(BEATS - 1));

  // NOTE: next_state gets its default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_req)        state_nxt = S_AW;
      S_AW:    if (awready)          state_nxt = S_W;
      S_W:     if (wready && is_last) state_nxt = S_B;
      S_B:     if (bvalid)           state_nxt = S_IDLE;
      default:                       state_nxt = S_IDLE;
    endcase
  end

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = unc_sel ? 8'd0 : 8'(BEATS - 1);
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awlock  = 2'b00;
  assign awvalid = (state == S_AW);

  assign wvalid  = (state == S_W);
  assign wdata   = line_q[32*cnt +: 32];
  assign wstrb   = strb_sel;
  assign wlast   = wvalid && is_last;

  assign bready  = (state == S_B);
  assign b_hs    = bready && bvalid;
  assign busy_o  = (state != S_IDLE);

  // The error flag accompanies whichever completion pulse the response belongs to.
  assign done_o     = b_hs && !unc_sel;
  assign resp_err_o = b_hs && (bresp != 2'b00);
`ifdef UNCACHE_WR_EN
  assign unc_done_o = b_hs && unc_sel;
`endif

endmodule

// File: tb/tb_axi_line_write_master.sv
// Directed self-checking bench for axi_line_write_master: reset, line bursts, backpressure, error response,
// mid-burst reset, back-to-back requests and (with UNCACHE_WR_EN) the uncached single-beat path.
module tb_axi_line_write_master;

  logic         clk = 1'b0;
  logic         rst;
  logic         wen_i;
  logic [31:0]  waddr_i;
  logic [127:0] wdata_i;
  logic         done_o, resp_err_o, busy_o;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic [3:0]   awcache;
  logic [2:0]   awprot;
  logic [1:0]   awlock;
  logic         awvalid, awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast, wvalid, wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid, bready;
`ifdef UNCACHE_WR_EN
  logic         unc_req_i;
  logic [31:0]  unc_addr_i;
  logic [31:0]  unc_data_i;
  logic [3:0]   unc_strb_i;
  logic         unc_done_o;
`endif

  axi_line_write_master dut (
    .clk(clk), .rst(rst), .wen_i(wen_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .done_o(done_o), .resp_err_o(resp_err_o), .busy_o(busy_o),
`ifdef UNCACHE_WR_EN
    .unc_req_i(unc_req_i), .unc_addr_i(unc_addr_i), .unc_data_i(unc_data_i),
    .unc_strb_i(unc_strb_i), .unc_done_o(unc_done_o),
`endif
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awcache(awcache), .awprot(awprot), .awlock(awlock), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected transaction, set by the stimulus before each request.
  logic [31:0]  exp_addr;
  logic [127:0] exp_line;
  logic [3:0]   exp_strb;
  int           exp_beats = 4;
  int           beat_n = 0;
  int           aw_n = 0;
  int           done_cnt = 0;
  int           unc_done_cnt = 0;

  // Every valid cycle is compared against the expected beat, so a stall must hold the same word.
  always @(negedge clk) begin
    if (!rst) begin
      if (awvalid) begin
        check("awaddr", awaddr, exp_addr);
        check("awlen", awlen, 8'(exp_beats - 1));
        if (awready) aw_n++;
      end
      if (wvalid) begin
        if (beat_n >= exp_beats) begin
          check("beat_overrun", beat_n, exp_beats);
        end else begin
          check("wdata", wdata, exp_line[32*beat_n +: 32]);
          check("wstrb", wstrb, exp_strb);
          check("wlast", wlast, (beat_n == exp_beats - 1));
        end
        if (wready) beat_n++;
      end
      if (done_o) done_cnt++;
`ifdef UNCACHE_WR_EN
      if (unc_done_o) unc_done_cnt++;
`endif
    end
  end

  task automatic run_req(input logic [31:0] addr, input logic [127:0] data, input int aw_delay,
                         input bit w_toggle, input logic [1:0] resp, input bit keep_wen, input int exp_lat);
    int cyc;
    int aw_wait;
    int done0;
    bit seen;
    bit flip;
    logic err_seen;
    exp_addr = {addr[31:4], 4'b0000};
    exp_line = data;
    exp_beats = 4;
    exp_strb = 4'b1111;
    beat_n = 0;
    aw_n = 0;
    done0 = done_cnt;
    wen_i = 1'b1;
    waddr_i = addr;
    wdata_i = data;
    awready = (aw_delay == 0);
    wready = 1'b1;
    bvalid = 1'b1;
    bresp = resp;
    cyc = 1;
    aw_wait = 0;
    seen = 0;
    err_seen = 1'b0;
    while (cyc <= 60 && !seen) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1;
        err_seen = resp_err_o;
        if (!keep_wen) wen_i = 1'b0;
      end else begin
        if (awvalid) aw_wait++;
        flip = w_toggle && wvalid;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == 2) begin
          waddr_i = ~addr;
          wdata_i = ~data;
        end
        awready = (aw_wait >= aw_delay);
        if (flip) wready = ~wready;
      end
    end
    if (!seen) begin
      check("done_timeout", 1'b0, 1'b1);
    end else begin
      check("latency", cyc, exp_lat);
      check("resp_err", err_seen, (resp != 2'b00));
    end
    @(posedge clk);
    #1;
    check("done_count", done_cnt - done0, 1);
    check("aw_count", aw_n, 1);
    check("beat_count", beat_n, 4);
    awready = 1'b1;
    wready = 1'b1;
  endtask

  initial begin
    int guard;
    int done0;
    rst = 1'b1;
    wen_i = 1'b0;
    waddr_i = '0;
    wdata_i = '0;
    awready = 1'b1;
    wready = 1'b1;
    bvalid = 1'b0;
    bresp = 2'b00;
    bid = 4'b0101;
    exp_addr = '0;
    exp_line = '0;
    exp_strb = 4'b1111;
`ifdef UNCACHE_WR_EN
    unc_req_i = 1'b0;
    unc_addr_i = '0;
    unc_data_i = '0;
    unc_strb_i = '0;
`endif
    #1;
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_wlast", wlast, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_resp_err", resp_err_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_awaddr", awaddr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("awid", awid, 4'b0001);
    check("awsize_burst", {awsize, awburst, awcache, awprot, awlock}, {3'b010, 2'b01, 4'b0000, 3'b000, 2'b00});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic line write, all readies high.
    run_req(32'h1FC0_0014, 128'h44444444_33333333_22222222_11111111, 0, 0, 2'b00, 0, 7);
    check("idle_busy", busy_o, 1'b0);

    // Backpressure: awready after 3 stalled cycles, wready toggling.
    run_req(32'h0000_2228, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 3, 1, 2'b00, 0, 13);

    // Error response; both pulses gone in the following cycle.
    run_req(32'h8000_0040, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 0, 0, 2'b10, 0, 7);
    @(negedge clk);
    check("err_done_next", done_o, 1'b0);
    check("err_flag_next", resp_err_o, 1'b0);
    @(posedge clk);
    #1;

    // Reset asserted right after the second beat.
    exp_addr = 32'h0000_1230;
    exp_line = 128'h55555555_66666666_77777777_88888888;
    exp_beats = 4;
    exp_strb = 4'b1111;
    beat_n = 0;
    aw_n = 0;
    done0 = done_cnt;
    wen_i = 1'b1;
    waddr_i = 32'h0000_123C;
    wdata_i = exp_line;
    guard = 0;
    while (beat_n < 2 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    check("rst_mid_reach_beat2", beat_n, 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wen_i = 1'b0;
    #1;
    check("rst_mid_awvalid", awvalid, 1'b0);
    check("rst_mid_wvalid", wvalid, 1'b0);
    check("rst_mid_busy", busy_o, 1'b0);
    check("rst_mid_done", done_o, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mid_no_done", done_cnt - done0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_req(32'h0000_1230, 128'h55555555_66666666_77777777_88888888, 0, 0, 2'b00, 0, 7);

    // Back-to-back: wen_i stays high across done_o with a new line presented.
    done0 = done_cnt;
    run_req(32'h0001_0008, 128'h01010101_02020202_03030303_04040404, 0, 0, 2'b00, 1, 7);
    waddr_i = 32'h0002_00F4;
    wdata_i = 128'hA0A0A0A0_B0B0B0B0_C0C0C0C0_D0D0D0D0;
    run_req(32'h0002_00F4, 128'hA0A0A0A0_B0B0B0B0_C0C0C0C0_D0D0D0D0, 0, 0, 2'b00, 0, 7);
    check("b2b_done_total", done_cnt - done0, 2);

`ifdef UNCACHE_WR_EN
    // Uncached single beat wins over a simultaneous line request.
    done0 = done_cnt;
    exp_addr = 32'hBFAF_8004;
    exp_line = {96'd0, 32'hCAFE_F00D};
    exp_beats = 1;
    exp_strb = 4'b0011;
    beat_n = 0;
    aw_n = 0;
    bvalid = 1'b1;
    bresp = 2'b00;
    unc_req_i = 1'b1;
    unc_addr_i = 32'hBFAF_8004;
    unc_data_i = 32'hCAFE_F00D;
    unc_strb_i = 4'b0011;
    wen_i = 1'b1;
    waddr_i = 32'h0003_0010;
    wdata_i = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;
    guard = 0;
    while (!unc_done_o && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    check("unc_done_seen", unc_done_o, 1'b1);
    check("unc_line_done_low", done_o, 1'b0);
    check("unc_beats", beat_n, 1);
    check("unc_aw", aw_n, 1);
    unc_req_i = 1'b0;
    exp_addr = 32'h0003_0010;
    exp_line = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;
    exp_beats = 4;
    exp_strb = 4'b1111;
    beat_n = 0;
    aw_n = 0;
    guard = 0;
    @(negedge clk);
    while (!done_o && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    check("unc_then_line_done", done_o, 1'b1);
    wen_i = 1'b0;
    @(posedge clk);
    #1;
    check("unc_then_line_beats", beat_n, 4);
    check("unc_done_count", unc_done_cnt, 1);
    check("unc_line_done_count", done_cnt - done0, 1);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("final_idle", busy_o, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
